// File: rtl/synth_key_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | synth_pkg: scan codes, parameter defaults, decoder state, helpers        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package synth_pkg;

    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;

    localparam logic [7:0] SC_OCT_DN   = 8'h1A;
    localparam logic [7:0] SC_OCT_UP   = 8'h22;
    localparam logic [7:0] SC_AMP_DN   = 8'h4E;
    localparam logic [7:0] SC_AMP_UP   = 8'h55;
    localparam logic [7:0] SC_ADSR_DN  = 8'h54;
    localparam logic [7:0] SC_ADSR_UP  = 8'h5B;
    localparam logic [7:0] SC_ADSR_SEL = 8'h0D;

    localparam logic [5:0] PARAM_MAX       = 6'd63;
    localparam logic [5:0] AMP_DEFAULT     = 6'd63;
    localparam logic [5:0] ATTACK_DEFAULT  = 6'd63;
    localparam logic [5:0] DECAY_DEFAULT   = 6'd0;
    localparam logic [5:0] SUSTAIN_DEFAULT = 6'd63;
    localparam logic [5:0] REL_DEFAULT     = 6'd63;
    localparam int unsigned OCT_DEFAULT_C  = 4;
    localparam logic [2:0] OCT_MAX         = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] num;
    } note_lookup_t;

    function automatic note_lookup_t note_lookup(input logic [7:0] code);
        note_lookup_t r;
        r.hit = 1'b1;
        r.num = 4'd0;
        case (code)
            8'h1C:   r.num = 4'd0;
            8'h1D:   r.num = 4'd1;
            8'h1B:   r.num = 4'd2;
            8'h24:   r.num = 4'd3;
            8'h23:   r.num = 4'd4;
            8'h2B:   r.num = 4'd5;
            8'h2C:   r.num = 4'd6;
            8'h34:   r.num = 4'd7;
            8'h35:   r.num = 4'd8;
            8'h33:   r.num = 4'd9;
            8'h3C:   r.num = 4'd10;
            8'h3B:   r.num = 4'd11;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // One spare bit absorbs the carry/borrow so the result clamps instead of wrapping.
    function automatic logic [5:0] sat_add(input logic [5:0] v, input logic [5:0] step);
        logic [6:0] s;
        s = {1'b0, v} + {1'b0, step};
        return (s > {1'b0, PARAM_MAX}) ? PARAM_MAX : s[5:0];
    endfunction

    function automatic logic [5:0] sat_sub(input logic [5:0] v, input logic [5:0] step);
        logic [6:0] s;
        s = {1'b0, v} - {1'b0, step};
        return s[6] ? 6'd0 : s[5:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/synth_key_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | synth_key_ctrl_if: PS/2 byte input and synth parameter outputs           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface synth_key_ctrl_if;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic       note_in;
    logic [3:0] note;
    logic       note_trig;
    logic [2:0] octave;
    logic [5:0] amplitude;
    logic [5:0] attack;
    logic [5:0] decay;
    logic [5:0] sustain;
    logic [5:0] rel;
    logic [1:0] adsr_sel;

    modport master (
        output ps2_data, ps2_valid,
        input  note_in, note, note_trig, octave, amplitude,
               attack, decay, sustain, rel, adsr_sel
    );

    modport slave (
        input  ps2_data, ps2_valid,
        output note_in, note, note_trig, octave, amplitude,
               attack, decay, sustain, rel, adsr_sel
    );
endinterface

`default_nettype wire

// File: rtl/synth_key_ctrl_event_decoder.sv
// +--------------------------------------------------------------------------+
// | ps2_event_decoder: make/break/extended prefix FSM with prefix timeout    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ps2_event_decoder
    import synth_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic       evt_valid,
    output logic       evt_break,
    output logic [7:0] evt_code
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign expired  = (state_q != ST_IDLE) && (timer_q == TIMER_LAST);
    assign evt_code = ps2_data;

    // A byte arriving on the expiry cycle is still decoded in the current state.
    always_comb begin
        state_d   = state_q;
        evt_valid = 1'b0;
        evt_break = 1'b0;
        if (ps2_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (ps2_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        evt_valid = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (ps2_data != SC_BRK) begin
                        evt_valid = 1'b1;
                        evt_break = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    state_d = (ps2_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (expired) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (ps2_valid || (state_d == ST_IDLE)) begin
            timer_d = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/synth_key_ctrl.sv
// +--------------------------------------------------------------------------+
// | synth_key_ctrl: key events to note on/off and saturating synth params    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module synth_key_ctrl
    import synth_pkg::*;
#(
    parameter int unsigned STEP        = 1,
    parameter int unsigned TIMEOUT     = 50000,
    parameter int unsigned OCT_DEFAULT = OCT_DEFAULT_C
) (
    input  logic              clk,
    input  logic              reset,
    synth_key_ctrl_if.slave   bus
);

    localparam logic [5:0] STEP_V = 6'(STEP);

    logic         evt_valid;
    logic         evt_break;
    logic [7:0]   evt_code;
    note_lookup_t lk;

    logic       note_in_q,   note_in_d;
    logic [3:0] note_q,      note_d;
    logic       note_trig_q, note_trig_d;
    logic [2:0] octave_q,    octave_d;
    logic [5:0] amp_q,       amp_d;
    logic [5:0] attack_q,    attack_d;
    logic [5:0] decay_q,     decay_d;
    logic [5:0] sustain_q,   sustain_d;
    logic [5:0] rel_q,       rel_d;
    logic [1:0] sel_q,       sel_d;

    ps2_event_decoder #(
        .TIMEOUT (TIMEOUT)
    ) u_decoder (
        .clk       (clk),
        .reset     (reset),
        .ps2_data  (bus.ps2_data),
        .ps2_valid (bus.ps2_valid),
        .evt_valid (evt_valid),
        .evt_break (evt_break),
        .evt_code  (evt_code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_in_q   <= 1'b0;
            note_q      <= 4'd0;
            note_trig_q <= 1'b0;
            octave_q    <= 3'(OCT_DEFAULT);
            amp_q       <= AMP_DEFAULT;
            attack_q    <= ATTACK_DEFAULT;
            decay_q     <= DECAY_DEFAULT;
            sustain_q   <= SUSTAIN_DEFAULT;
            rel_q       <= REL_DEFAULT;
            sel_q       <= 2'd0;
        end else begin
            note_in_q   <= note_in_d;
            note_q      <= note_d;
            note_trig_q <= note_trig_d;
            octave_q    <= octave_d;
            amp_q       <= amp_d;
            attack_q    <= attack_d;
            decay_q     <= decay_d;
            sustain_q   <= sustain_d;
            rel_q       <= rel_d;
            sel_q       <= sel_d;
        end
    end

    assign lk = note_lookup(evt_code);

    always_comb begin
        note_in_d   = note_in_q;
        note_d      = note_q;
        note_trig_d = 1'b0;
        octave_d    = octave_q;
        amp_d       = amp_q;
        attack_d    = attack_q;
        decay_d     = decay_q;
        sustain_d   = sustain_q;
        rel_d       = rel_q;
        sel_d       = sel_q;
        if (evt_valid) begin
            if (lk.hit) begin
                // Last-note priority: only the sounding key's release silences it.
                if (!evt_break) begin
                    if (!note_in_q || (lk.num != note_q)) begin
                        note_d      = lk.num;
                        note_in_d   = 1'b1;
                        note_trig_d = 1'b1;
                    end
                end else if (note_in_q && (lk.num == note_q)) begin
                    note_in_d = 1'b0;
                end
            end else if (!evt_break) begin
                case (evt_code)
                    SC_OCT_DN:   if (octave_q != 3'd0)   octave_d = octave_q - 3'd1;
                    SC_OCT_UP:   if (octave_q != OCT_MAX) octave_d = octave_q + 3'd1;
                    SC_AMP_DN:   amp_d = sat_sub(amp_q, STEP_V);
                    SC_AMP_UP:   amp_d = sat_add(amp_q, STEP_V);
                    SC_ADSR_SEL: sel_d = sel_q + 2'd1;
                    SC_ADSR_DN: begin
                        case (sel_q)
                            2'd0:    attack_d  = sat_sub(attack_q, STEP_V);
                            2'd1:    decay_d   = sat_sub(decay_q, STEP_V);
                            2'd2:    sustain_d = sat_sub(sustain_q, STEP_V);
                            default: rel_d     = sat_sub(rel_q, STEP_V);
                        endcase
                    end
                    SC_ADSR_UP: begin
                        case (sel_q)
                            2'd0:    attack_d  = sat_add(attack_q, STEP_V);
                            2'd1:    decay_d   = sat_add(decay_q, STEP_V);
                            2'd2:    sustain_d = sat_add(sustain_q, STEP_V);
                            default: rel_d     = sat_add(rel_q, STEP_V);
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.note_in   = note_in_q;
    assign bus.note      = note_q;
    assign bus.note_trig = note_trig_q;
    assign bus.octave    = octave_q;
    assign bus.amplitude = amp_q;
    assign bus.attack    = attack_q;
    assign bus.decay     = decay_q;
    assign bus.sustain   = sustain_q;
    assign bus.rel       = rel_q;
    assign bus.adsr_sel  = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_synth_key_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_synth_key_ctrl: directed byte vectors with queued expected snapshots  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_synth_key_ctrl;

    localparam int unsigned STEP    = 4;
    localparam int unsigned TIMEOUT = 32;

    typedef struct packed {
        logic       note_in;
        logic [3:0] note;
        logic       note_trig;
        logic [2:0] octave;
        logic [5:0] amplitude;
        logic [5:0] attack;
        logic [5:0] decay;
        logic [5:0] sustain;
        logic [5:0] rel;
        logic [1:0] adsr_sel;
    } snap_t;

    logic clk;
    logic reset;
    logic snap_req;

    synth_key_ctrl_if bus ();

    synth_key_ctrl #(
        .STEP        (STEP),
        .TIMEOUT     (TIMEOUT),
        .OCT_DEFAULT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    snap_t exp_s;
    snap_t exp_q[$];
    int    id_q[$];
    int    vec_id;
    int    n_total;
    int    n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t defaults();
        snap_t s;
        s.note_in   = 1'b0;
        s.note      = 4'd0;
        s.note_trig = 1'b0;
        s.octave    = 3'd4;
        s.amplitude = 6'd63;
        s.attack    = 6'd63;
        s.decay     = 6'd0;
        s.sustain   = 6'd63;
        s.rel       = 6'd63;
        s.adsr_sel  = 2'd0;
        return s;
    endfunction

    function automatic snap_t actual();
        snap_t s;
        s.note_in   = bus.note_in;
        s.note      = bus.note;
        s.note_trig = bus.note_trig;
        s.octave    = bus.octave;
        s.amplitude = bus.amplitude;
        s.attack    = bus.attack;
        s.decay     = bus.decay;
        s.sustain   = bus.sustain;
        s.rel       = bus.rel;
        s.adsr_sel  = bus.adsr_sel;
        return s;
    endfunction

    // note_trig is a pulse, so the expectation is cleared once queued.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.ps2_data  = b;
        bus.ps2_valid = 1'b1;
        exp_q.push_back(exp_s);
        id_q.push_back(vec_id);
        vec_id++;
        exp_s.note_trig = 1'b0;
        @(negedge clk);
        bus.ps2_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic snap();
        @(negedge clk);
        snap_req = 1'b1;
        exp_q.push_back(exp_s);
        id_q.push_back(vec_id);
        vec_id++;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    initial begin
        snap_t e;
        snap_t a;
        int    id;
        forever begin
            @(posedge clk);
            if (bus.ps2_valid || snap_req) begin
                #1;
                n_total++;
                a = actual();
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_output actual=%h required=none", a);
                end else begin
                    e  = exp_q.pop_front();
                    id = id_q.pop_front();
                    if (a !== e)
                        $display("FAIL vec%0d actual=%h required=%h", id, a, e);
                    else
                        n_pass++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        n_total       = 0;
        n_pass        = 0;
        vec_id        = 0;
        snap_req      = 1'b0;
        bus.ps2_data  = 8'h00;
        bus.ps2_valid = 1'b0;
        reset         = 1'b1;
        exp_s         = defaults();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        snap();

        // Note on, typematic repeat, release
        exp_s.note_in = 1'b1; exp_s.note = 4'd0; exp_s.note_trig = 1'b1;
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        exp_s.note_in = 1'b0;
        send(8'h1C);

        // Last-note priority
        exp_s.note_in = 1'b1; exp_s.note_trig = 1'b1;
        send(8'h1C);
        exp_s.note = 4'd4; exp_s.note_trig = 1'b1;
        send(8'h23);
        send(8'hF0); send(8'h1C);
        send(8'hF0);
        exp_s.note_in = 1'b0;
        send(8'h23);

        // Octave saturation and decrement
        exp_s.octave = 3'd5; send(8'h22);
        exp_s.octave = 3'd6; send(8'h22);
        exp_s.octave = 3'd7; send(8'h22);
        send(8'h22);
        send(8'h22);
        exp_s.octave = 3'd6; send(8'h1A);

        // Amplitude saturation both ways
        send(8'h55);
        for (int i = 1; i <= 17; i++) begin
            v = 63 - 4 * i;
            exp_s.amplitude = (v < 0) ? 6'd0 : 6'(v);
            send(8'h4E);
        end
        exp_s.amplitude = 6'd4; send(8'h55);

        // ADSR select and adjust
        exp_s.adsr_sel = 2'd1; send(8'h0D);
        exp_s.adsr_sel = 2'd2; send(8'h0D);
        exp_s.sustain  = 6'd59; send(8'h54);
        exp_s.adsr_sel = 2'd3; send(8'h0D);
        exp_s.adsr_sel = 2'd0; send(8'h0D);
        send(8'h5B);
        exp_s.attack   = 6'd59; send(8'h54);
        exp_s.adsr_sel = 2'd1; send(8'h0D);
        send(8'h54);
        exp_s.decay    = 6'd4; send(8'h5B);
        exp_s.adsr_sel = 2'd2; send(8'h0D);
        exp_s.adsr_sel = 2'd3; send(8'h0D);
        exp_s.rel      = 6'd59; send(8'h54);
        exp_s.adsr_sel = 2'd0; send(8'h0D);

        // Control key break ignored, unmapped code ignored
        send(8'hF0); send(8'h55);
        send(8'h77);

        // Prefix timeout: the following byte is a make
        send(8'hF0);
        repeat (TIMEOUT + 4) @(negedge clk);
        snap();
        exp_s.note_in = 1'b1; exp_s.note = 4'd0; exp_s.note_trig = 1'b1;
        send(8'h1C);

        // Extended sequences have no effect
        send(8'hE0); send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h23);

        // Reset in the middle of a break prefix
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_s = defaults();
        snap();
        exp_s.note_in = 1'b1; exp_s.note_trig = 1'b1;
        send(8'h1C);

        repeat (5) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
